regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 65 ++++++
 rtl/regfile_writeback.sv | 125 ++++++++++++
 tb/tb_regfile_writeback.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_writeback_pkg                                                |
// | Shared constants and entry type for the register-file write-back     |
// | queue.                                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package regfile_writeback_pkg;

  // Default register write data width.
  localparam int XLEN  = 32;
  // Register index width (x0..x31).
  localparam int REG_W = 5;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_fifo                                                              |
// | Pending-write queue: entry storage, read/write pointers and count.   |
// | All entries are exposed so the owner can search them for            |
// | forwarding.                                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_fifo #(
  parameter int XLEN  = regfile_writeback_pkg::XLEN,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          i_push,
  input  logic [regfile_writeback_pkg::REG_W-1:0]       i_push_rd,
  input  logic [XLEN-1:0]                               i_push_data,
  input  logic                                          i_pop,
  output logic [PW-1:0]                                 o_rd_ptr,
  output logic [CW-1:0]                                 o_count,
  output logic [DEPTH-1:0][regfile_writeback_pkg::REG_W-1:0] o_ent_rd,
  output logic [DEPTH-1:0][XLEN-1:0]                    o_ent_data
);
  import regfile_writeback_pkg::*;

  logic [PW-1:0]                r_wr_ptr;
  logic [PW-1:0]                r_rd_ptr;
  logic [CW-1:0]                r_count;
  logic [DEPTH-1:0][REG_W-1:0]  r_ent_rd;
  logic [DEPTH-1:0][XLEN-1:0]   r_ent_data;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is only meaningful below count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_ent_rd[r_wr_ptr]   <= i_push_rd;
      r_ent_data[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_rd_ptr   = r_rd_ptr;
  assign o_count    = r_count;
  assign o_ent_rd   = r_ent_rd;
  assign o_ent_data = r_ent_data;

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_writeback                                                    |
// | Arbitrates load/ALU write offers into a pending-write queue, drives  |
// | the register-file write port from the queue head, and forwards the   |
// | youngest pending data for two read addresses.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_writeback #(
  parameter int XLEN  = regfile_writeback_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    load_valid,
  input  logic [regfile_writeback_pkg::REG_W-1:0] load_rd,
  input  logic [XLEN-1:0]                         load_data,
  output logic                                    load_ready,
  input  logic                                    alu_valid,
  input  logic [regfile_writeback_pkg::REG_W-1:0] alu_rd,
  input  logic [XLEN-1:0]                         alu_data,
  output logic                                    alu_ready,
  input  logic                                    wb_stall,
  output logic [regfile_writeback_pkg::REG_W-1:0] rd,
  output logic [XLEN-1:0]                         wrs3,
  output logic                                    we,
  input  logic [regfile_writeback_pkg::REG_W-1:0] rs1,
  input  logic [regfile_writeback_pkg::REG_W-1:0] rs2,
  output logic                                    fwd1_hit,
  output logic                                    fwd2_hit,
  output logic [XLEN-1:0]                         fwd1_data,
  output logic [XLEN-1:0]                         fwd2_data
);
  import regfile_writeback_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]               w_rd_ptr;
  logic [CW-1:0]               w_count;
  logic [DEPTH-1:0][REG_W-1:0] w_ent_rd;
  logic [DEPTH-1:0][XLEN-1:0]  w_ent_data;
  logic                        w_nonempty;
  logic                        w_pop;
  logic                        w_load_ready;
  logic                        w_acc_load;
  logic                        w_acc_alu;
  logic                        w_push;
  logic [REG_W-1:0]            w_push_rd;
  logic [XLEN-1:0]             w_push_data;
  logic [XLEN:0]               w_fwd1;
  logic [XLEN:0]               w_fwd2;

  wb_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .i_push      (w_push),
    .i_push_rd   (w_push_rd),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_rd_ptr    (w_rd_ptr),
    .o_count     (w_count),
    .o_ent_rd    (w_ent_rd),
    .o_ent_data  (w_ent_data)
  );

  // Youngest valid entry matching rs wins; x0 never matches. Result is {hit, data}.
  function automatic logic [XLEN:0] f_lookup(
    input logic [REG_W-1:0]              rs,
    input logic [PW-1:0]                 rd_ptr,
    input logic [CW-1:0]                 count,
    input logic [DEPTH-1:0][REG_W-1:0]   ent_rd,
    input logic [DEPTH-1:0][XLEN-1:0]    ent_data
  );
    logic [XLEN:0] res;
    logic [PW-1:0] idx;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (rs != '0) && (ent_rd[idx] == rs)) begin
        res = {1'b1, ent_data[idx]};
      end
    end
    return res;
  endfunction

  // Handshake: the head drains unless stalled; a drain frees a slot for this cycle's offer.
  always_comb begin
    w_nonempty   = (w_count != '0) && !reset;
    w_pop        = w_nonempty && !wb_stall;
    w_load_ready = !reset && ((w_count < CW'(DEPTH)) || w_pop);
    w_acc_load   = load_valid && w_load_ready;
    w_acc_alu    = alu_valid && w_load_ready && !load_valid;
    w_push_rd    = w_acc_load ? load_rd   : alu_rd;
    w_push_data  = w_acc_load ? load_data : alu_data;
    // Writes to x0 complete the handshake but are dropped here.
    w_push       = (w_acc_load || w_acc_alu) && (w_push_rd != '0);
  end

  // Forwarding search over queued entries only; the incoming offer is not visible yet.
  always_comb begin
    w_fwd1 = '0;
    w_fwd2 = '0;
    if (!reset) begin
      w_fwd1 = f_lookup(rs1, w_rd_ptr, w_count, w_ent_rd, w_ent_data);
      w_fwd2 = f_lookup(rs2, w_rd_ptr, w_count, w_ent_rd, w_ent_data);
    end
  end

  assign load_ready = w_load_ready;
  assign alu_ready  = w_load_ready && !load_valid;
  assign we         = w_nonempty;
  // Head comes straight from registers, so the write port is stable between posedges.
  assign rd         = w_nonempty ? w_ent_rd[w_rd_ptr]   : '0;
  assign wrs3       = w_nonempty ? w_ent_data[w_rd_ptr] : '0;
  assign fwd1_hit   = w_fwd1[XLEN];
  assign fwd1_data  = w_fwd1[XLEN-1:0];
  assign fwd2_hit   = w_fwd2[XLEN];
  assign fwd2_data  = w_fwd2[XLEN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_writeback                                                 |
// | Directed self-checking bench for regfile_writeback.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_regfile_writeback;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [4:0]  load_rd;
  logic [31:0] load_data;
  logic        load_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        wb_stall;
  logic [4:0]  rd;
  logic [31:0] wrs3;
  logic        we;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;

  int vectors;
  int miscompares;

  regfile_writeback #(
    .XLEN  (32),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_rd    (load_rd),
    .load_data  (load_data),
    .load_ready (load_ready),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .wb_stall   (wb_stall),
    .rd         (rd),
    .wrs3       (wrs3),
    .we         (we),
    .rs1        (rs1),
    .rs2        (rs2),
    .fwd1_hit   (fwd1_hit),
    .fwd2_hit   (fwd2_hit),
    .fwd1_data  (fwd1_data),
    .fwd2_data  (fwd2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset      = 1'b1;
    load_valid = 1'b0; load_rd = '0; load_data = '0;
    alu_valid  = 1'b0; alu_rd  = '0; alu_data  = '0;
    wb_stall   = 1'b0;
    rs1        = 5'd1; rs2 = 5'd2;

    // Reset state
    tick();
    chk("rst_we", we, 1'b0);
    chk("rst_load_ready", load_ready, 1'b0);
    chk("rst_alu_ready", alu_ready, 1'b0);
    chk("rst_fwd1_hit", fwd1_hit, 1'b0);
    chk("rst_fwd2_hit", fwd2_hit, 1'b0);
    reset = 1'b0;

    // Single ALU write, one cycle latency, one cycle of we
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1;
    chk("t1_alu_ready", alu_ready, 1'b1);
    chk("t1_we_before", we, 1'b0);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("t1_we", we, 1'b1);
    chk("t1_rd", rd, 5'd5);
    chk("t1_wrs3", wrs3, 32'h0000_1234);
    tick();
    chk("t1_we_after", we, 1'b0);

    // Load priority over ALU; ALU written one cycle after the load
    load_valid = 1'b1; load_rd = 5'd3; load_data = 32'h33;
    alu_valid  = 1'b1; alu_rd  = 5'd4; alu_data  = 32'h44;
    #1;
    chk("t2_load_ready", load_ready, 1'b1);
    chk("t2_alu_ready", alu_ready, 1'b0);
    tick();
    load_valid = 1'b0;
    #1;
    chk("t2_alu_ready2", alu_ready, 1'b1);
    chk("t2_rd_load", rd, 5'd3);
    chk("t2_wrs3_load", wrs3, 32'h33);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("t2_rd_alu", rd, 5'd4);
    chk("t2_wrs3_alu", wrs3, 32'h44);
    tick();
    chk("t2_we_after", we, 1'b0);

    // Write to x0 is handshaken but dropped
    load_valid = 1'b1; load_rd = 5'd0; load_data = 32'hDEAD;
    #1;
    chk("t3_load_ready", load_ready, 1'b1);
    tick();
    load_valid = 1'b0;
    #1;
    chk("t3_we", we, 1'b0);
    tick();
    chk("t3_we2", we, 1'b0);

    // Stall: fill four entries, fifth offer refused
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      load_valid = 1'b1; load_rd = 5'(i); load_data = 32'h100 + 32'(i);
      tick();
    end
    load_rd = 5'd5; load_data = 32'h105;
    #1;
    chk("t4_full_load_ready", load_ready, 1'b0);
    chk("t4_full_alu_ready", alu_ready, 1'b0);
    chk("t4_head_rd", rd, 5'd1);
    tick();
    // Release stall: push at full with a pop is accepted
    wb_stall = 1'b0; load_rd = 5'd9; load_data = 32'h909;
    #1;
    chk("t4_full_pop_ready", load_ready, 1'b1);
    chk("t4_rd1", rd, 5'd1);
    chk("t4_wrs3_1", wrs3, 32'h101);
    tick();
    load_valid = 1'b0;
    #1;
    chk("t4_rd2", rd, 5'd2);
    chk("t4_wrs3_2", wrs3, 32'h102);
    tick();
    chk("t4_rd3", rd, 5'd3);
    tick();
    chk("t4_rd4", rd, 5'd4);
    chk("t4_wrs3_4", wrs3, 32'h104);
    tick();
    chk("t4_rd9", rd, 5'd9);
    chk("t4_wrs3_9", wrs3, 32'h909);
    tick();
    chk("t4_we_after", we, 1'b0);

    // Forwarding: youngest match wins, x0 never hits, incoming offer excluded
    wb_stall = 1'b1;
    load_valid = 1'b1; load_rd = 5'd7; load_data = 32'hA;
    tick();
    load_data = 32'hB;
    tick();
    load_rd = 5'd8; load_data = 32'h88;
    rs1 = 5'd7; rs2 = 5'd0;
    #1;
    chk("t5_fwd1_hit", fwd1_hit, 1'b1);
    chk("t5_fwd1_data", fwd1_data, 32'hB);
    chk("t5_fwd2_hit_x0", fwd2_hit, 1'b0);
    chk("t5_fwd2_data_x0", fwd2_data, 32'h0);
    rs2 = 5'd8;
    #1;
    chk("t5_fwd2_offer_excl", fwd2_hit, 1'b0);
    tick();
    load_valid = 1'b0;
    #1;
    chk("t5_fwd2_hit", fwd2_hit, 1'b1);
    chk("t5_fwd2_data", fwd2_data, 32'h88);
    chk("t5_head_rd", rd, 5'd7);
    chk("t5_head_wrs3", wrs3, 32'hA);

    // Reset pulse between edges with three entries queued
    chk("t6_we_pre", we, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_we_rst", we, 1'b0);
    chk("t6_load_ready_rst", load_ready, 1'b0);
    chk("t6_fwd1_hit_rst", fwd1_hit, 1'b0);
    reset = 1'b0;
    wb_stall = 1'b0;
    #1;
    chk("t6_we_post", we, 1'b0);
    chk("t6_fwd1_post", fwd1_hit, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_we_drain", we, 1'b0);
    end

    // Queue usable again after reset
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    tick();
    alu_valid = 1'b0;
    #1;
    chk("t7_we", we, 1'b1);
    chk("t7_rd", rd, 5'd2);
    chk("t7_wrs3", wrs3, 32'h22);
    tick();
    chk("t7_we_after", we, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
